// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master engine between N_REQ requesters.
// It enforces an idle gap between frames and aborts transfers the engine never finishes.
module spi_xfer_arbiter #(
   parameter int N_REQ          = 2,
   parameter int WIDTH          = 13,
   parameter int GAP_CYCLES     = 27,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_dat,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic                   err,
   output logic [WIDTH-1:0]       rsp_dat,
   output logic                   busy,
   output logic                   spi_start,
   output logic [WIDTH-1:0]       spi_tx,
   input  logic                   spi_done,
   input  logic [WIDTH-1:0]       spi_rx
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
   localparam logic [GW-1:0]    GAP_LOAD   = GW'(GAP_CYCLES);
   localparam logic [GW-1:0]    GAP_ONE    = GW'(1);
   localparam logic [IW-1:0]    LAST_RST   = IW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t            state_r, state_nxt;
   logic [N_REQ-1:0]  gnt_r, gnt_nxt;
   logic [N_REQ-1:0]  ack_r, ack_nxt;
   logic              err_r, err_nxt;
   logic [WIDTH-1:0]  rsp_r, rsp_nxt;
   logic              busy_r, busy_nxt;
   logic              start_r, start_nxt;
   logic [WIDTH-1:0]  tx_r, tx_nxt;
   logic [TW-1:0]     timer_r, timer_nxt;
   logic [GW-1:0]     gap_r, gap_nxt;
   logic [IW-1:0]     last_r, last_nxt;
   logic [IW-1:0]     idx_r, idx_nxt;
   logic [IW-1:0]     pick_s;
   logic              xfer_end_s;

   // First requester at or after last+1 (mod N_REQ); only meaningful when r != 0.
   function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] last);
      logic [IW-1:0] sel;
      logic          found;
      int            j;
      sel   = last;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         j = (int'(last) + i) % N_REQ;
         if (!found && r[j]) begin
            sel   = IW'(j);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return sel;
   endfunction

   assign pick_s = rr_pick(req, last_r);

   // Next-state and next-output logic for the IDLE -> WAIT -> GAP cycle.
   always_comb begin
      state_nxt  = state_r;
      gnt_nxt    = gnt_r;
      ack_nxt    = '0;
      err_nxt    = 1'b0;
      rsp_nxt    = rsp_r;
      busy_nxt   = busy_r;
      start_nxt  = 1'b0;
      tx_nxt     = tx_r;
      timer_nxt  = timer_r;
      gap_nxt    = gap_r;
      last_nxt   = last_r;
      idx_nxt    = idx_r;
      xfer_end_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|req) begin
               idx_nxt   = pick_s;
               gnt_nxt   = ONE_HOT0 << pick_s;
               tx_nxt    = req_dat[int'(pick_s)*WIDTH +: WIDTH];
               start_nxt = 1'b1;
               busy_nxt  = 1'b1;
               timer_nxt = '0;
               state_nxt = ST_WAIT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Done is checked first so a completion on the timeout cycle is not an error.
            if (spi_done) begin
               rsp_nxt    = spi_rx;
               err_nxt    = 1'b0;
               xfer_end_s = 1'b1;
            end else if (timer_r == TIMER_LAST) begin
               rsp_nxt    = '0;
               err_nxt    = 1'b1;
               xfer_end_s = 1'b1;
            end else begin
               timer_nxt = timer_r + TIMER_ONE;
            end
            if (xfer_end_s) begin
               ack_nxt  = ONE_HOT0 << idx_r;
               gnt_nxt  = '0;
               last_nxt = idx_r;
               if (GAP_CYCLES == 0) begin
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
               end else begin
                  state_nxt = ST_GAP;
                  gap_nxt   = GAP_LOAD;
               end
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_GAP: begin
            if (gap_r == GAP_ONE) begin
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
               gap_nxt   = '0;
            end else begin
               gap_nxt = gap_r - GAP_ONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         gnt_r   <= '0;
         ack_r   <= '0;
         err_r   <= 1'b0;
         rsp_r   <= '0;
         busy_r  <= 1'b0;
         start_r <= 1'b0;
         tx_r    <= '0;
         timer_r <= '0;
         gap_r   <= '0;
         last_r  <= LAST_RST;
         idx_r   <= '0;
      end else begin
         state_r <= state_nxt;
         gnt_r   <= gnt_nxt;
         ack_r   <= ack_nxt;
         err_r   <= err_nxt;
         rsp_r   <= rsp_nxt;
         busy_r  <= busy_nxt;
         start_r <= start_nxt;
         tx_r    <= tx_nxt;
         timer_r <= timer_nxt;
         gap_r   <= gap_nxt;
         last_r  <= last_nxt;
         idx_r   <= idx_nxt;
      end
   end

   assign gnt       = gnt_r;
   assign ack       = ack_r;
   assign err       = err_r;
   assign rsp_dat   = rsp_r;
   assign busy      = busy_r;
   assign spi_start = start_r;
   assign spi_tx    = tx_r;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: unit A (2 requesters, gap 27, long timeout)
// and unit B (3 requesters, no gap, timeout 50) checked against a round-robin reference.
module tb_spi_xfer_arbiter;
   localparam int W = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [1:0]   a_req, a_gnt, a_ack;
   logic [2*W-1:0] a_req_dat;
   logic         a_err, a_busy, a_start, a_done;
   logic [W-1:0] a_rsp, a_tx, a_rx;

   logic [2:0]   b_req, b_gnt, b_ack;
   logic [3*W-1:0] b_req_dat;
   logic         b_err, b_busy, b_start, b_done;
   logic [W-1:0] b_rsp, b_tx, b_rx;

   spi_xfer_arbiter #(.N_REQ(2), .WIDTH(W), .GAP_CYCLES(27), .TIMEOUT_CYCLES(65535)) dut_a (
      .clk(clk), .rst(rst), .req(a_req), .req_dat(a_req_dat), .gnt(a_gnt), .ack(a_ack),
      .err(a_err), .rsp_dat(a_rsp), .busy(a_busy), .spi_start(a_start), .spi_tx(a_tx),
      .spi_done(a_done), .spi_rx(a_rx));

   spi_xfer_arbiter #(.N_REQ(3), .WIDTH(W), .GAP_CYCLES(0), .TIMEOUT_CYCLES(50)) dut_b (
      .clk(clk), .rst(rst), .req(b_req), .req_dat(b_req_dat), .gnt(b_gnt), .ack(b_ack),
      .err(b_err), .rsp_dat(b_rsp), .busy(b_busy), .spi_start(b_start), .spi_tx(b_tx),
      .spi_done(b_done), .spi_rx(b_rx));

   function automatic logic [2:0] f_gnt(input bit s);   return s ? b_gnt : {1'b0, a_gnt}; endfunction
   function automatic logic [2:0] f_ack(input bit s);   return s ? b_ack : {1'b0, a_ack}; endfunction
   function automatic logic       f_start(input bit s); return s ? b_start : a_start;      endfunction
   function automatic logic       f_err(input bit s);   return s ? b_err : a_err;          endfunction
   function automatic logic [W-1:0] f_rsp(input bit s); return s ? b_rsp : a_rsp;          endfunction
   function automatic logic [W-1:0] f_tx(input bit s);  return s ? b_tx : a_tx;            endfunction

   task automatic set_req(input bit s, input logic [2:0] m);
      if (s) b_req = m; else a_req = m[1:0];
   endtask

   task automatic set_dat(input bit s, input int i, input logic [W-1:0] d);
      if (s) b_req_dat[i*W +: W] = d; else a_req_dat[i*W +: W] = d;
   endtask

   task automatic set_done(input bit s, input logic d, input logic [W-1:0] rx);
      if (s) begin b_done = d; b_rx = rx; end else begin a_done = d; a_rx = rx; end
   endtask

   // Engine model: completes F cycles after the launch edge; call on the negedge spi_start is seen.
   task automatic serve(input bit s, input int f, input logic [W-1:0] rx);
      repeat (f - 1) @(negedge clk);
      set_done(s, 1'b1, rx);
      @(negedge clk);
      set_done(s, 1'b0, rx);
   endtask

   // kind 0 waits for spi_start, kind 1 for any ack; n = negedges elapsed.
   task automatic wait_evt(input bit s, input int kind, input int limit, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         if (kind == 0 ? f_start(s) : (f_ack(s) != 3'b000)) ok = 1'b1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      a_req = '0; b_req = '0; a_done = 1'b0; b_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      a_req = '0; b_req = '0; a_done = 1'b0; b_done = 1'b0;
      a_rx = '0; b_rx = '0; a_req_dat = '0; b_req_dat = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({a_gnt, a_ack, a_err, a_rsp, a_busy, a_start, a_tx} !== '0) begin
         n_fail++; $display("FAIL reset_a: outputs %h, expected all zero", {a_gnt, a_ack, a_err, a_rsp, a_busy, a_start, a_tx});
      end
      n_checks++;
      if ({b_gnt, b_ack, b_err, b_rsp, b_busy, b_start, b_tx} !== '0) begin
         n_fail++; $display("FAIL reset_b: outputs %h, expected all zero", {b_gnt, b_ack, b_err, b_rsp, b_busy, b_start, b_tx});
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok; int n;
      apply_reset();
      set_dat(0, 0, 13'h1dad);
      set_req(0, 3'b001);
      wait_evt(0, 0, 5, ok, n);
      n_checks++;
      if (!ok || n != 1) begin n_fail++; $display("FAIL single_latency: start after %0d cycles (seen=%0d), expected 1", n, ok); end
      n_checks++;
      if (a_tx !== 13'h1dad || a_gnt !== 2'b01 || a_busy !== 1'b1) begin
         n_fail++; $display("FAIL single_launch: tx=%h gnt=%b busy=%b, expected 1dad 01 1", a_tx, a_gnt, a_busy);
      end
      @(negedge clk);
      n_checks++;
      if (a_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: start=%b, expected 0", a_start); end
      serve(0, 99, 13'h0ced);
      n_checks++;
      if (a_ack !== 2'b01 || a_err !== 1'b0 || a_rsp !== 13'h0ced || a_gnt !== 2'b00) begin
         n_fail++; $display("FAIL single_ack: ack=%b err=%b rsp=%h gnt=%b, expected 01 0 0ced 00", a_ack, a_err, a_rsp, a_gnt);
      end
      set_req(0, 3'b000);
      @(negedge clk);
      n_checks++;
      if (a_ack !== 2'b00 || a_rsp !== 13'h0ced) begin
         n_fail++; $display("FAIL single_ack_pulse: ack=%b rsp=%h, expected 00 0ced", a_ack, a_rsp);
      end
   endtask

   // Requests held; expected owner order comes from the round-robin rule applied to the mask.
   task automatic test_random(input bit s, input int iters);
      int nreq, gap, last, owner, f, n, j;
      bit ok;
      logic [W-1:0] dat [3];
      logic [W-1:0] rx, old_tx;
      logic [2:0] m, oh;
      nreq = s ? 3 : 2;
      gap  = s ? 0 : 27;
      apply_reset();
      last = nreq - 1;
      for (int i = 0; i < nreq; i++) begin
         dat[i] = W'($urandom);
         set_dat(s, i, dat[i]);
      end
      m = 3'(s ? 3'b111 : 3'b011);
      set_req(s, m);
      for (int k = 0; k < iters; k++) begin
         owner = -1;
         for (int t = 1; t <= nreq; t++) begin
            j = (last + t) % nreq;
            if (owner < 0 && m[j]) owner = j;
         end
         oh = 3'(1 << owner);
         wait_evt(s, 0, gap + 6, ok, n);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL rr_start_timeout: no start within %0d cycles (unit %0d)", n, s); return; end
         if (k > 0) begin
            n_checks++;
            if (n != gap + 1) begin n_fail++; $display("FAIL rr_spacing: ack-to-start %0d cycles, expected %0d (unit %0d)", n, gap + 1, s); end
         end
         n_checks++;
         if (f_gnt(s) !== oh || f_tx(s) !== dat[owner]) begin
            n_fail++; $display("FAIL rr_grant: gnt=%b tx=%h, expected %b %h (unit %0d)", f_gnt(s), f_tx(s), oh, dat[owner], s);
         end
         old_tx = dat[owner];
         dat[owner] = W'($urandom);
         set_dat(s, owner, dat[owner]);
         if ($urandom_range(0, 1) == 1) begin
            m[owner] = 1'b0;
            set_req(s, m);
         end
         f  = $urandom_range(1, 30);
         rx = W'($urandom);
         serve(s, f, rx);
         n_checks++;
         if (f_ack(s) !== oh || f_err(s) !== 1'b0 || f_rsp(s) !== rx || f_tx(s) !== old_tx) begin
            n_fail++; $display("FAIL rr_ack: ack=%b err=%b rsp=%h tx=%h, expected %b 0 %h %h (unit %0d)",
                               f_ack(s), f_err(s), f_rsp(s), f_tx(s), oh, rx, old_tx, s);
         end
         last = owner;
         m[owner] = 1'($urandom_range(0, 1));
         m = m | 3'($urandom_range(0, (1 << nreq) - 1));
         if (m == 3'b000) m = 3'b001;
         set_req(s, m);
      end
      set_req(s, 3'b000);
   endtask

   task automatic test_timeout();
      bit ok; int n1, n2;
      logic [W-1:0] rx;
      apply_reset();
      rx = W'($urandom) | 13'h0001;
      set_dat(1, 0, 13'h0a5a);
      set_req(1, 3'b001);
      wait_evt(1, 0, 5, ok, n1);
      set_req(1, 3'b000);
      serve(1, 5, rx);
      n_checks++;
      if (b_ack !== 3'b001 || b_rsp !== rx) begin n_fail++; $display("FAIL to_setup: ack=%b rsp=%h, expected 001 %h", b_ack, b_rsp, rx); end
      set_dat(1, 1, 13'h1234);
      set_req(1, 3'b010);
      wait_evt(1, 0, 5, ok, n1);
      n_checks++;
      if (!ok || b_gnt !== 3'b010) begin n_fail++; $display("FAIL to_start: seen=%0d gnt=%b, expected 1 010", ok, b_gnt); end
      wait_evt(1, 1, 80, ok, n2);
      n_checks++;
      if (!ok || n2 != 50) begin n_fail++; $display("FAIL to_latency: ack after %0d cycles (seen=%0d), expected 50", n2, ok); end
      n_checks++;
      if (b_ack !== 3'b010 || b_err !== 1'b1 || b_rsp !== 13'h0000 || b_busy !== 1'b0) begin
         n_fail++; $display("FAIL to_ack: ack=%b err=%b rsp=%h busy=%b, expected 010 1 0000 0", b_ack, b_err, b_rsp, b_busy);
      end
      set_req(1, 3'b000);
      @(negedge clk);
      n_checks++;
      if (b_ack !== 3'b000 || b_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: ack=%b err=%b, expected 000 0", b_ack, b_err); end
   endtask

   task automatic test_exact_timeout();
      bit ok; int n;
      logic [W-1:0] rx;
      rx = W'($urandom) | 13'h0100;
      set_dat(1, 2, 13'h0777);
      set_req(1, 3'b100);
      wait_evt(1, 0, 5, ok, n);
      n_checks++;
      if (!ok || b_gnt !== 3'b100) begin n_fail++; $display("FAIL exact_start: seen=%0d gnt=%b, expected 1 100", ok, b_gnt); end
      set_req(1, 3'b000);
      serve(1, 50, rx);
      n_checks++;
      if (b_ack !== 3'b100 || b_err !== 1'b0 || b_rsp !== rx) begin
         n_fail++; $display("FAIL exact_done_wins: ack=%b err=%b rsp=%h, expected 100 0 %h", b_ack, b_err, b_rsp, rx);
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int n, starts;
      logic [W-1:0] rx;
      apply_reset();
      set_dat(0, 0, 13'h0f0f);
      set_req(0, 3'b001);
      wait_evt(0, 0, 5, ok, n);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      set_req(0, 3'b000);
      @(negedge clk);
      n_checks++;
      if (a_gnt !== 2'b00 || a_busy !== 1'b0 || a_ack !== 2'b00 || a_start !== 1'b0) begin
         n_fail++; $display("FAIL midrst_state: gnt=%b busy=%b ack=%b start=%b, expected 00 0 00 0", a_gnt, a_busy, a_ack, a_start);
      end
      rst = 1'b0;
      starts = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (a_start || a_ack != 2'b00) starts++;
      end
      n_checks++;
      if (starts != 0) begin n_fail++; $display("FAIL midrst_quiet: %0d start/ack cycles, expected 0", starts); end
      set_dat(0, 1, 13'h15a3);
      set_req(0, 3'b010);
      wait_evt(0, 0, 5, ok, n);
      n_checks++;
      if (!ok || a_gnt !== 2'b10 || a_tx !== 13'h15a3) begin
         n_fail++; $display("FAIL midrst_regrant: seen=%0d gnt=%b tx=%h, expected 1 10 15a3", ok, a_gnt, a_tx);
      end
      rx = W'($urandom);
      serve(0, 7, rx);
      n_checks++;
      if (a_ack !== 2'b10 || a_err !== 1'b0 || a_rsp !== rx) begin
         n_fail++; $display("FAIL midrst_ack: ack=%b err=%b rsp=%h, expected 10 0 %h", a_ack, a_err, a_rsp, rx);
      end
      set_req(0, 3'b000);
   endtask

   task automatic test_spurious_done();
      bit ok; int n, acks, rsp_bad;
      logic [W-1:0] r1;
      apply_reset();
      r1 = W'($urandom) | 13'h0002;
      set_dat(0, 0, 13'h0123);
      set_req(0, 3'b001);
      wait_evt(0, 0, 5, ok, n);
      serve(0, 3, r1);
      set_req(0, 3'b000);
      n_checks++;
      if (a_ack !== 2'b01 || a_rsp !== r1) begin n_fail++; $display("FAIL spur_setup: ack=%b rsp=%h, expected 01 %h", a_ack, a_rsp, r1); end
      acks = 0; rsp_bad = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3 || i == 32) set_done(0, 1'b1, ~r1);
         else set_done(0, 1'b0, ~r1);
         @(negedge clk);
         if (a_ack != 2'b00) acks++;
         if (a_rsp !== r1) rsp_bad++;
         if (i == 30) begin
            n_checks++;
            if (a_busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle: busy=%b, expected 0", a_busy); end
         end
      end
      n_checks++;
      if (acks != 0) begin n_fail++; $display("FAIL spur_ack: %0d ack cycles, expected 0", acks); end
      n_checks++;
      if (rsp_bad != 0) begin n_fail++; $display("FAIL spur_rsp: rsp changed in %0d cycles, expected 0", rsp_bad); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      a_req = '0; b_req = '0; a_done = 1'b0; b_done = 1'b0;
      a_rx = '0; b_rx = '0; a_req_dat = '0; b_req_dat = '0;
      test_reset();
      test_single();
      test_random(1'b0, 4);
      test_random(1'b0, 6);
      test_random(1'b1, 14);
      test_timeout();
      test_exact_timeout();
      test_reset_mid();
      test_spurious_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
